multicycle_control_unit: RTL and testbench

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/riscv_ctrl_pkg.sv | 29 ++
 rtl/alu_decoder.sv | 25 ++
 rtl/multicycle_control_unit.sv | 144 ++++++++++++++
 tb/tb_multicycle_control_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared state encoding, opcodes and ALU codes for the multicycle controller.
// Defining BRANCH_EXT_EN widens the set of legal branch funct3 values.
package riscv_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH, S_JAL, S_ILLEGAL
  } state_t;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  function automatic logic branch_legal(input logic [2:0] f3);
`ifdef BRANCH_EXT_EN
    return f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b100 || f3 == 3'b101;
`else
    return f3 == 3'b000;
`endif
  endfunction
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps ALUOp plus instruction funct fields to the ALU operation select.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [2:0] Funct3,
  input  logic       Funct7b5,
  input  logic       op5,
  output logic [2:0] ALUControl
);
  logic [2:0] w_funct;
  always_comb begin
    w_funct = ALU_ADD;
    case (Funct3)
      3'b000: w_funct = (op5 & Funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010: w_funct = ALU_SLT;
      3'b110: w_funct = ALU_OR;
      3'b111: w_funct = ALU_AND;
      default: w_funct = ALU_ADD;
    endcase
    ALUControl = ALUOp == ALUOP_ADD   ? ALU_ADD :
                 ALUOp == ALUOP_SUB   ? ALU_SUB :
                 ALUOp == ALUOP_FUNCT ? w_funct : ALU_ADD;
  end
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore FSM controller for a multicycle RV32 subset.
// Optional macro BRANCH_EXT_EN adds bne/blt/bge branch conditions.
module multicycle_control_unit
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] Funct3,
  input  logic       Funct7b5,
  input  logic       Zero,
  input  logic       LT,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       Illegal,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl
);
  state_t     r_state, w_next;
  logic [2:0] r_wait;
  logic       w_wait_done, w_taken, w_pc_update, w_irw, w_mw, w_rw;
  logic [1:0] w_alu_op;
  assign w_wait_done = r_wait == 3'(MEM_WAIT);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_wait  <= 3'd0;
    end else begin
      r_state <= w_next;
      r_wait  <= (w_next == r_state && (r_state == S_FETCH || r_state == S_MEMREAD)) ? r_wait + 3'd1 : 3'd0;
    end
  end
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:    w_next = w_wait_done ? S_DECODE : S_FETCH;
      S_DECODE:   w_next = (op == OP_LOAD || op == OP_STORE)          ? S_MEMADR   :
                           op == OP_RTYPE                              ? S_EXECUTER :
                           op == OP_ITYPE                              ? S_EXECUTEI :
                           (op == OP_BRANCH && branch_legal(Funct3))   ? S_BRANCH   :
                           op == OP_JAL                                ? S_JAL      : S_ILLEGAL;
      S_MEMADR:   w_next = op == OP_LOAD ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  w_next = w_wait_done ? S_MEMWB : S_MEMREAD;
      S_EXECUTER: w_next = S_ALUWB;
      S_EXECUTEI: w_next = S_ALUWB;
      S_JAL:      w_next = S_ALUWB;
      S_ILLEGAL:  w_next = S_ILLEGAL;
      default:    w_next = S_FETCH;
    endcase
  end
  // LT only matters for the extended branch set; tied off otherwise
  always_comb begin
`ifdef BRANCH_EXT_EN
    w_taken = Funct3 == 3'b000 ? Zero  :
              Funct3 == 3'b001 ? ~Zero :
              Funct3 == 3'b100 ? LT    :
              Funct3 == 3'b101 ? ~LT   : 1'b0;
`else
    w_taken = Zero | (LT & 1'b0);
`endif
  end
  always_comb begin
    w_alu_op    = ALUOP_ADD;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ResultSrc   = 2'b00;
    AdrSrc      = 1'b0;
    w_irw       = 1'b0;
    w_mw        = 1'b0;
    w_rw        = 1'b0;
    w_pc_update = 1'b0;
    case (r_state)
      S_FETCH: begin
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
        w_irw       = w_wait_done;
        w_pc_update = w_wait_done;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        w_rw      = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        w_mw   = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA  = 2'b10;
        w_alu_op = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ALUSrcA  = 2'b10;
        ALUSrcB  = 2'b01;
        w_alu_op = ALUOP_FUNCT;
      end
      S_ALUWB: w_rw = 1'b1;
      S_BRANCH: begin
        ALUSrcA  = 2'b10;
        w_alu_op = ALUOP_SUB;
      end
      S_JAL: begin
        ALUSrcA     = 2'b01;
        ALUSrcB     = 2'b10;
        w_pc_update = 1'b1;
      end
      default: ;
    endcase
  end
  // strobes are held off for the whole reset pulse, not just after the state settles
  always_comb begin
    PCWrite  = ~rst & (w_pc_update | (r_state == S_BRANCH & w_taken));
    IRWrite  = ~rst & w_irw;
    MemWrite = ~rst & w_mw;
    RegWrite = ~rst & w_rw;
    Illegal  = r_state == S_ILLEGAL;
    ImmSrc   = op == OP_STORE  ? 2'b01 :
               op == OP_BRANCH ? 2'b10 :
               op == OP_JAL    ? 2'b11 : 2'b00;
  end
  alu_decoder u_alu_decoder (
    .ALUOp      (w_alu_op),
    .Funct3     (Funct3),
    .Funct7b5   (Funct7b5),
    .op5        (op[5]),
    .ALUControl (ALUControl)
  );
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: table, directed and random checks of the controller at MEM_WAIT 0 and 2.
// Expectations follow BRANCH_EXT_EN when it is defined for the build.
module tb_multicycle_control_unit;
  typedef struct packed {
    logic pcw, adr, irw, mw, rw, ill;
    logic [1:0] rs, sa, sb, imm;
    logic [2:0] alu;
  } o_t;
  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic f7, z, lt;
    int len;
    logic [2:0] alu;
    logic [1:0] imm;
    logic pcw;
  } vec_t;
  logic clk = 0, rst = 1, f7 = 0, zero = 0, lt = 0, sel = 0;
  logic [6:0] op = 0;
  logic [2:0] f3 = 0;
  logic d0_pcw, d0_adr, d0_irw, d0_mw, d0_rw, d0_ill;
  logic d2_pcw, d2_adr, d2_irw, d2_mw, d2_rw, d2_ill;
  logic [1:0] d0_rs, d0_sa, d0_sb, d0_imm, d2_rs, d2_sa, d2_sb, d2_imm;
  logic [2:0] d0_alu, d2_alu;
  o_t a0, a2, act;
  o_t exp_q[$];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  multicycle_control_unit #(.MEM_WAIT(0)) dut0 (
    .clk(clk), .rst(rst), .op(op), .Funct3(f3), .Funct7b5(f7), .Zero(zero), .LT(lt),
    .PCWrite(d0_pcw), .AdrSrc(d0_adr), .IRWrite(d0_irw), .MemWrite(d0_mw), .RegWrite(d0_rw),
    .Illegal(d0_ill), .ResultSrc(d0_rs), .ALUSrcA(d0_sa), .ALUSrcB(d0_sb), .ImmSrc(d0_imm),
    .ALUControl(d0_alu));
  multicycle_control_unit #(.MEM_WAIT(2)) dut2 (
    .clk(clk), .rst(rst), .op(op), .Funct3(f3), .Funct7b5(f7), .Zero(zero), .LT(lt),
    .PCWrite(d2_pcw), .AdrSrc(d2_adr), .IRWrite(d2_irw), .MemWrite(d2_mw), .RegWrite(d2_rw),
    .Illegal(d2_ill), .ResultSrc(d2_rs), .ALUSrcA(d2_sa), .ALUSrcB(d2_sb), .ImmSrc(d2_imm),
    .ALUControl(d2_alu));
  assign a0  = {d0_pcw, d0_adr, d0_irw, d0_mw, d0_rw, d0_ill, d0_rs, d0_sa, d0_sb, d0_imm, d0_alu};
  assign a2  = {d2_pcw, d2_adr, d2_irw, d2_mw, d2_rw, d2_ill, d2_rs, d2_sa, d2_sb, d2_imm, d2_alu};
  assign act = sel ? a2 : a0;
  function automatic logic [2:0] alu_f(logic [1:0] aluop, logic [2:0] fn3, logic fn7, logic op5);
    if (aluop == 2'b00) return 3'b000;
    if (aluop == 2'b01) return 3'b001;
    if (aluop != 2'b10) return 3'b000;
    case (fn3)
      3'b000: return (op5 & fn7) ? 3'b001 : 3'b000;
      3'b010: return 3'b101;
      3'b110: return 3'b011;
      3'b111: return 3'b010;
      default: return 3'b000;
    endcase
  endfunction
  function automatic logic [1:0] imm_f(logic [6:0] o);
    return o == 7'b0100011 ? 2'b01 : o == 7'b1100011 ? 2'b10 : o == 7'b1101111 ? 2'b11 : 2'b00;
  endfunction
  function automatic logic legal_br(logic [2:0] fn3);
`ifdef BRANCH_EXT_EN
    return fn3 inside {3'b000, 3'b001, 3'b100, 3'b101};
`else
    return fn3 == 3'b000;
`endif
  endfunction
  function automatic logic taken_f(logic [2:0] fn3, logic z, logic l);
`ifdef BRANCH_EXT_EN
    return fn3 == 3'b000 ? z : fn3 == 3'b001 ? ~z : fn3 == 3'b100 ? l : ~l;
`else
    return z;
`endif
  endfunction
  function automatic o_t rst_exp(logic [6:0] o);
    o_t c = '0;
    c.imm = imm_f(o);
    c.sb = 2'b10;
    c.rs = 2'b10;
    return c;
  endfunction
  // Expected per-cycle outputs for one whole instruction; returns 1 if it traps.
  function automatic logic gen(int w, logic [6:0] o, logic [2:0] fn3, logic fn7, logic z, logic l);
    o_t b = '0, c;
    b.imm = imm_f(o);
    exp_q.delete();
    for (int i = 0; i <= w; i++) begin
      c = b; c.sb = 2'b10; c.rs = 2'b10;
      if (i == w) begin c.irw = 1; c.pcw = 1; end
      exp_q.push_back(c);
    end
    c = b; c.sa = 2'b01; c.sb = 2'b01; exp_q.push_back(c);
    if (o == 7'b0000011 || o == 7'b0100011) begin
      c = b; c.sa = 2'b10; c.sb = 2'b01; exp_q.push_back(c);
      if (o == 7'b0000011) begin
        for (int i = 0; i <= w; i++) begin c = b; c.adr = 1; exp_q.push_back(c); end
        c = b; c.rs = 2'b01; c.rw = 1; exp_q.push_back(c);
      end else begin
        c = b; c.adr = 1; c.mw = 1; exp_q.push_back(c);
      end
    end else if (o == 7'b0110011 || o == 7'b0010011) begin
      c = b; c.sa = 2'b10; c.sb = o[5] ? 2'b00 : 2'b01; c.alu = alu_f(2'b10, fn3, fn7, o[5]);
      exp_q.push_back(c);
      c = b; c.rw = 1; exp_q.push_back(c);
    end else if (o == 7'b1100011 && legal_br(fn3)) begin
      c = b; c.sa = 2'b10; c.alu = 3'b001; c.pcw = taken_f(fn3, z, l); exp_q.push_back(c);
    end else if (o == 7'b1101111) begin
      c = b; c.sa = 2'b01; c.sb = 2'b10; c.pcw = 1; exp_q.push_back(c);
      c = b; c.rw = 1; exp_q.push_back(c);
    end else begin
      for (int i = 0; i < 3; i++) begin c = b; c.ill = 1; exp_q.push_back(c); end
      return 1;
    end
    return 0;
  endfunction
  task automatic chk(string name, o_t e);
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, act, e);
    end
  endtask
  task automatic chkv(string name, int got, int e);
    checks++;
    if (got != e) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, e);
    end
  endtask
  task automatic run_seq(string name);
    foreach (exp_q[i]) begin
      #1 chk(name, exp_q[i]);
      @(negedge clk);
    end
  endtask
  task automatic reset_chk();
    rst = 1;
    #1 chk("rst_hold", rst_exp(op));
    @(negedge clk);
    rst = 0;
  endtask
  task automatic start(logic s, logic [6:0] o, logic [2:0] fn3, logic fn7, logic z, logic l);
    sel = s; rst = 1;
    @(negedge clk);
    op = o; f3 = fn3; f7 = fn7; zero = z; lt = l; rst = 0;
  endtask
  vec_t tbl[$];
  initial begin
    int len, pos, cnt;
    logic [2:0] alu2;
    logic lastp, trap;
    logic [6:0] ops[6] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
    tbl = '{
      '{7'b0000011, 3'd2, 0, 0, 0, 5, 3'b000, 2'b00, 0},
      '{7'b0100011, 3'd2, 0, 0, 0, 4, 3'b000, 2'b01, 0},
      '{7'b0110011, 3'd0, 1, 0, 0, 4, 3'b001, 2'b00, 0},
      '{7'b0110011, 3'd0, 0, 0, 0, 4, 3'b000, 2'b00, 0},
      '{7'b0110011, 3'd2, 0, 0, 0, 4, 3'b101, 2'b00, 0},
      '{7'b0110011, 3'd6, 0, 0, 0, 4, 3'b011, 2'b00, 0},
      '{7'b0110011, 3'd7, 0, 0, 0, 4, 3'b010, 2'b00, 0},
      '{7'b0010011, 3'd0, 1, 0, 0, 4, 3'b000, 2'b00, 0},
      '{7'b0010011, 3'd3, 0, 0, 0, 4, 3'b000, 2'b00, 0},
      '{7'b1100011, 3'd0, 0, 1, 0, 3, 3'b001, 2'b10, 1},
      '{7'b1100011, 3'd0, 0, 0, 1, 3, 3'b001, 2'b10, 0},
      '{7'b1101111, 3'd0, 0, 0, 0, 4, 3'b000, 2'b11, 0}};
    @(negedge clk);
    #1 chk("reset_state", rst_exp(op));
    @(negedge clk);
    foreach (tbl[r]) begin
      start(0, tbl[r].op, tbl[r].f3, tbl[r].f7, tbl[r].z, tbl[r].lt);
      len = -1; alu2 = 'x; lastp = 'x;
      for (int n = 0; n < 20; n++) begin
        #1;
        if (n == 2) alu2 = a0.alu;
        if (n > 0 && a0.irw) begin len = n; break; end
        lastp = a0.pcw;
        @(negedge clk);
      end
      chkv($sformatf("tbl%0d_len", r), len, tbl[r].len);
      chkv($sformatf("tbl%0d_alu", r), alu2, tbl[r].alu);
      chkv($sformatf("tbl%0d_imm", r), a0.imm, tbl[r].imm);
      chkv($sformatf("tbl%0d_pcw", r), lastp, tbl[r].pcw);
    end
    start(1, 7'b0110011, 3'd0, 1, 0, 0);
    cnt = 0; pos = -1; alu2 = 'x;
    for (int n = 0; n < 7; n++) begin
      #1;
      if (a2.irw) begin cnt++; pos = n; end
      if (n == 4) alu2 = a2.alu;
      if (a2.rw) chkv("w2_wb_cycle", n, 5);
      @(negedge clk);
    end
    chkv("w2_irw_count", cnt, 1);
    chkv("w2_irw_cycle", pos, 2);
    chkv("w2_exec_alu", alu2, 3'b001);
    start(0, 7'b1100011, 3'd4, 0, 0, 1);
    repeat (2) @(negedge clk);
`ifdef BRANCH_EXT_EN
    #1 chkv("blt_pcw", a0.pcw, 1);
`else
    for (int n = 0; n < 4; n++) begin
      #1 chkv("blt_illegal", {a0.ill, a0.pcw, a0.irw, a0.mw, a0.rw}, 5'b10000);
      @(negedge clk);
    end
`endif
    start(0, 7'b0000000, 3'd0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1 chkv("op0_illegal", a0.ill, 1);
    @(negedge clk);
    rst = 1;
    #1 chkv("op0_rst_ill", a0.ill, 0);
    @(negedge clk);
    rst = 0;
    #1 chkv("op0_post_fetch", {a0.ill, a0.irw}, 2'b01);
    start(0, 7'b0100011, 3'd2, 0, 0, 0);
    repeat (3) @(negedge clk);
    #1 chkv("sw_memwrite", a0.mw, 1);
    #2 rst = 1;
    #1 chk("sw_rst_drop", rst_exp(op));
    @(negedge clk);
    rst = 0;
    #1 chkv("sw_after_rst", a0.irw, 1);
    for (int s = 0; s < 2; s++) begin
      start(s[0], 0, 0, 0, 0, 0);
      for (int k = 0; k < 40; k++) begin
        int pick = $urandom_range(0, 6);
        op = pick == 6 ? 7'($urandom) : ops[pick];
        f3 = 3'($urandom); f7 = 1'($urandom); zero = 1'($urandom); lt = 1'($urandom);
        trap = gen(s * 2, op, f3, f7, zero, lt);
        run_seq($sformatf("rand_w%0d_k%0d", s * 2, k));
        if (trap) reset_chk();
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
